fetch_sequencer: RTL and testbench

Sequential front-end controller that owns the program counter, the Z/V/N flag register and instruction fetch for the 16-bit CPU. It issues requests to instruction memory, hands each fetched instruction to the datapath with a valid/ready handshake, resolves conditional branches (B immediate, BR register) against the registered flags, and stops the machine on HLT. It sits between instruction memory and the decode/execute datapath and is the only writer of the PC.

---
 rtl/cpu_pkg.sv | 31 +++
 rtl/branch_cond.sv | 31 +++
 rtl/fetch_sequencer.sv | 113 +++++++++++
 tb/tb_fetch_sequencer.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared opcode, condition, state and flag definitions for the CPU front end
package cpu_pkg;

    localparam logic [3:0] OP_B   = 4'hC;
    localparam logic [3:0] OP_BR  = 4'hD;
    localparam logic [3:0] OP_HLT = 4'hF;

    // Flag vector layout is {Z,V,N}
    localparam int FLAG_Z = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_N = 0;

    typedef enum logic [2:0] {
        COND_NE     = 3'b000,
        COND_EQ     = 3'b001,
        COND_GT     = 3'b010,
        COND_LT     = 3'b011,
        COND_GE     = 3'b100,
        COND_LE     = 3'b101,
        COND_OV     = 3'b110,
        COND_UNCOND = 3'b111
    } cond_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_ISSUE = 2'd2,
        ST_HALT  = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/branch_cond.sv
// rtl/branch_cond.sv - combinational branch condition evaluation against {Z,V,N}
module branch_cond
    import cpu_pkg::*;
(
    input  cond_t      cond,
    input  logic [2:0] flags,
    output logic       taken
);

    logic z, v, n;

    assign z = flags[FLAG_Z];
    assign v = flags[FLAG_V];
    assign n = flags[FLAG_N];

    always_comb begin
        taken = 1'b0;
        case (cond)
            COND_NE:     taken = ~z;
            COND_EQ:     taken = z;
            COND_GT:     taken = ~z & ~n;
            COND_LT:     taken = n;
            COND_GE:     taken = z | ~n;
            COND_LE:     taken = z | n;
            COND_OV:     taken = v;
            COND_UNCOND: taken = 1'b1;
            default:     taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - PC, flag register and fetch/issue sequencing with branch resolution
module fetch_sequencer
    import cpu_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_valid,
    input  logic [15:0] imem_data,
    output logic [15:0] instr_out,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [15:0] pc_plus2,
    input  logic [15:0] rs_data,
    input  logic [2:0]  flag_we,
    input  logic [2:0]  flag_in,
    output logic [2:0]  flags,
    output logic        halted
);

    fetch_state_t state_q;
    logic [15:0]  pc_q;
    logic [15:0]  ir_q;
    logic [2:0]   flags_q;
    logic         req_q;
    logic         valid_q;
    logic         halted_q;

    logic [15:0]  pc_next_d;
    logic [15:0]  b_target;
    logic [3:0]   opcode;
    logic         taken;

    assign opcode   = ir_q[15:12];
    assign pc_plus2 = pc_q + 16'd2;
    // Offset is a signed word count: sign-extend 9 bits, then scale to bytes
    assign b_target = pc_plus2 + {{6{ir_q[8]}}, ir_q[8:0], 1'b0};

    branch_cond u_branch_cond (
        .cond  (cond_t'(ir_q[11:9])),
        .flags (flags_q),
        .taken (taken)
    );

    always_comb begin
        pc_next_d = pc_plus2;
        if (opcode == OP_B && taken) begin
            pc_next_d = b_target;
        end else if (opcode == OP_BR && taken) begin
            pc_next_d = rs_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            pc_q     <= RESET_PC;
            ir_q     <= 16'h0000;
            flags_q  <= 3'b000;
            req_q    <= 1'b0;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (flag_we[i]) flags_q[i] <= flag_in[i];
            end
            case (state_q)
                ST_IDLE: begin
                    state_q <= ST_FETCH;
                    req_q   <= 1'b1;
                end
                ST_FETCH: begin
                    if (imem_valid) begin
                        ir_q    <= imem_data;
                        state_q <= ST_ISSUE;
                        req_q   <= 1'b0;
                        valid_q <= 1'b1;
                    end
                end
                ST_ISSUE: begin
                    if (instr_ready) begin
                        valid_q <= 1'b0;
                        if (opcode == OP_HLT) begin
                            state_q  <= ST_HALT;
                            halted_q <= 1'b1;
                        end else begin
                            pc_q    <= pc_next_d;
                            state_q <= ST_FETCH;
                            req_q   <= 1'b1;
                        end
                    end
                end
                ST_HALT: begin
                    state_q <= ST_HALT;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = pc_q;
    assign instr_out   = ir_q;
    assign instr_valid = valid_q;
    assign flags       = flags_q;
    assign halted      = halted_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - directed self-checking bench for fetch_sequencer
module tb_fetch_sequencer;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_valid;
    logic [15:0] imem_data;
    logic [15:0] instr_out;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] pc_plus2;
    logic [15:0] rs_data;
    logic [2:0]  flag_we;
    logic [2:0]  flag_in;
    logic [2:0]  flags;
    logic        halted;

    int checks;
    int errors;
    logic [15:0] pc_m;

    fetch_sequencer #(.RESET_PC(16'h0000)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_valid  (imem_valid),
        .imem_data   (imem_data),
        .instr_out   (instr_out),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .pc_plus2    (pc_plus2),
        .rs_data     (rs_data),
        .flag_we     (flag_we),
        .flag_in     (flag_in),
        .flags       (flags),
        .halted      (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] mk(input logic [3:0] op, input logic [2:0] cond, input logic [8:0] off);
        return {op, cond, off};
    endfunction

    // Entered at a negedge with the DUT in FETCH; leaves it at a negedge back in FETCH
    task automatic run_instr(input string tag, input logic [15:0] instr, input logic [15:0] rs,
                             input logic [2:0] fwe, input logic [2:0] fin, input logic [15:0] exp_next);
        logic [15:0] exp_p2;
        exp_p2 = pc_m + 16'd2;
        check({tag, ".req"}, {15'd0, imem_req}, 16'd1);
        check({tag, ".addr"}, imem_addr, pc_m);
        imem_data  = instr;
        imem_valid = 1'b1;
        @(negedge clk);
        imem_valid = 1'b0;
        check({tag, ".ivalid"}, {15'd0, instr_valid}, 16'd1);
        check({tag, ".iout"}, instr_out, instr);
        check({tag, ".pcp2"}, pc_plus2, exp_p2);
        rs_data     = rs;
        instr_ready = 1'b1;
        flag_we     = fwe;
        flag_in     = fin;
        @(negedge clk);
        instr_ready = 1'b0;
        flag_we     = 3'b000;
        check({tag, ".next"}, imem_addr, exp_next);
        pc_m = exp_next;
    endtask

    task automatic write_flags(input logic [2:0] we, input logic [2:0] val, input logic [2:0] exp);
        flag_we = we;
        flag_in = val;
        @(negedge clk);
        flag_we = 3'b000;
        check("flags_wr", {13'd0, flags}, {13'd0, exp});
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        pc_m        = 16'h0000;
        rst_n       = 1'b0;
        imem_valid  = 1'b0;
        imem_data   = 16'h0000;
        instr_ready = 1'b0;
        rs_data     = 16'h0000;
        flag_we     = 3'b000;
        flag_in     = 3'b000;

        #12;
        check("rst.req",    {15'd0, imem_req},    16'd0);
        check("rst.ivalid", {15'd0, instr_valid}, 16'd0);
        check("rst.halted", {15'd0, halted},      16'd0);
        check("rst.addr",   imem_addr,            16'h0000);
        check("rst.iout",   instr_out,            16'h0000);
        check("rst.flags",  {13'd0, flags},       16'd0);

        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("idle.req", {15'd0, imem_req}, 16'd0);
        @(negedge clk);

        for (int k = 0; k < 4; k++) begin
            run_instr("add", 16'h1001 + 16'(k), 16'h0000, 3'b000, 3'b000, pc_m + 16'd2);
        end
        check("add.seq", imem_addr, 16'h0008);

        run_instr("br_unc",  mk(4'hD, 3'b111, 9'h000), 16'h1234, 3'b000, 3'b000, 16'h1234);
        run_instr("br_to10", mk(4'hD, 3'b111, 9'h000), 16'h0010, 3'b000, 3'b000, 16'h0010);

        write_flags(3'b111, 3'b100, 3'b100);
        run_instr("b_eq_t",  mk(4'hC, 3'b001, 9'h1FE), 16'h0000, 3'b000, 3'b000, 16'h000E);
        run_instr("br_to10b", mk(4'hD, 3'b111, 9'h000), 16'h0010, 3'b000, 3'b000, 16'h0010);
        write_flags(3'b100, 3'b000, 3'b000);
        run_instr("b_eq_nt", mk(4'hC, 3'b001, 9'h1FE), 16'h0000, 3'b000, 3'b000, 16'h0012);

        run_instr("br_gt_t",  mk(4'hD, 3'b010, 9'h000), 16'h0040, 3'b000, 3'b000, 16'h0040);
        write_flags(3'b001, 3'b001, 3'b001);
        run_instr("br_gt_nt", mk(4'hD, 3'b010, 9'h000), 16'h0080, 3'b000, 3'b000, 16'h0042);

        // Z set on the accepting edge must not steer this branch
        run_instr("b_eq_old", mk(4'hC, 3'b001, 9'h010), 16'h0000, 3'b100, 3'b100, 16'h0044);
        check("flags_after", {13'd0, flags}, 16'h0005);

        check("stall.req", {15'd0, imem_req}, 16'd1);
        imem_data  = 16'h2222;
        imem_valid = 1'b1;
        @(negedge clk);
        imem_valid = 1'b0;
        imem_data  = 16'h3333;
        for (int k = 0; k < 3; k++) begin
            check("stall.addr",   imem_addr,               16'h0044);
            check("stall.iout",   instr_out,               16'h2222);
            check("stall.ivalid", {15'd0, instr_valid},    16'd1);
            @(negedge clk);
        end
        instr_ready = 1'b1;
        @(negedge clk);
        instr_ready = 1'b0;
        check("stall.next", imem_addr, 16'h0046);
        pc_m = 16'h0046;

        run_instr("br_fffe",  mk(4'hD, 3'b111, 9'h000), 16'hFFFE, 3'b000, 3'b000, 16'hFFFE);
        run_instr("wrap_add", 16'h1000,                 16'h0000, 3'b000, 3'b000, 16'h0000);
        run_instr("b_back",   mk(4'hC, 3'b111, 9'h1FE), 16'h0000, 3'b000, 3'b000, 16'hFFFE);
        run_instr("br_fff0",  mk(4'hD, 3'b111, 9'h000), 16'hFFF0, 3'b000, 3'b000, 16'hFFF0);
        run_instr("b_fwrap",  mk(4'hC, 3'b111, 9'h0FF), 16'h0000, 3'b000, 3'b000, 16'h01F0);

        run_instr("br_to20", mk(4'hD, 3'b111, 9'h000), 16'h0020, 3'b000, 3'b000, 16'h0020);
        check("hlt.req0", {15'd0, imem_req}, 16'd1);
        imem_data  = 16'hF000;
        imem_valid = 1'b1;
        @(negedge clk);
        instr_ready = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            check("hlt.halted", {15'd0, halted},      16'd1);
            check("hlt.req",    {15'd0, imem_req},    16'd0);
            check("hlt.ivalid", {15'd0, instr_valid}, 16'd0);
            check("hlt.addr",   imem_addr,            16'h0020);
            @(negedge clk);
        end
        imem_valid  = 1'b0;
        instr_ready = 1'b0;
        write_flags(3'b010, 3'b010, 3'b111);

        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        pc_m  = 16'h0000;
        @(negedge clk);
        run_instr("post_hlt", 16'h1ABC, 16'h0000, 3'b000, 3'b000, 16'h0002);

        #2;
        rst_n = 1'b0;
        #1;
        check("arst.req",    {15'd0, imem_req},    16'd0);
        check("arst.addr",   imem_addr,            16'h0000);
        check("arst.iout",   instr_out,            16'h0000);
        check("arst.flags",  {13'd0, flags},       16'd0);
        check("arst.halted", {15'd0, halted},      16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("arst.idle", {15'd0, imem_req}, 16'd0);
        @(negedge clk);
        check("arst.fetch", {15'd0, imem_req}, 16'd1);
        check("arst.faddr", imem_addr, 16'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
